seg_scan_decoder: RTL and testbench

Reverse direction of the team's hex-to-7-segment encoders. Monitors a multiplexed, scanned 7-segment display bus and recovers the hex value being shown. Typical sources are an external board display or our own scanner output looped back for self-check. It debounces each digit dwell, decodes the segment pattern back to a nibble, assembles one full scan frame, and reports the value with a valid pulse or an error pulse. Sits in device_mgr next to the display drivers; used for loopback checking and for reading legacy display-only peripherals.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_scan_decoder_sig2hex.sv | 26 ++
 rtl/seg_scan_decoder.sv | 159 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Segment pattern tables, blanking code and FSM state type shared by the
// scanned-display decoder and its pattern lookup.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, entry i is the pattern for nibble i.
    localparam logic [15:0][6:0] SEG_STD = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [15:0][6:0] SEG_ROT = {
        7'h31, 7'h30, 7'h0C, 7'h70, 7'h18, 7'h01, 7'h02, 7'h00,
        7'h47, 7'h10, 7'h12, 7'h0B, 7'h06, 7'h24, 7'h4F, 7'h40
    };

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_decoder_sig2hex.sv
// Maps an active-low 7-segment pattern back to its hex nibble; ok=0 for unknown patterns.
// Latency: combinational; no flow control.
module sig2hex
    import seg_pkg::*;
#(
    parameter int ROTATE = 0
) (
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       ok
);

    localparam logic [15:0][6:0] TBL = (ROTATE != 0) ? SEG_ROT : SEG_STD;

    always_comb begin
        hex = 4'h0;
        ok  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == TBL[i]) begin
                hex = 4'(i);
                ok  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the hex value shown on a scanned 7-segment bus: sync, debounce, decode, frame assembly.
// Latency: 2 + STABLE_CYC + 1 cycles from last digit settling to o_valid; passive monitor, no backpressure.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 8,
    parameter int ROTATE     = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [6:0]             i_seg,
    input  logic [NUM_DIG-1:0]     i_dig,
    output logic [4*NUM_DIG-1:0]   o_value,
    output logic                   o_valid,
    output logic                   o_err,
    output logic [NUM_DIG-1:0]     o_err_dig
);

    localparam int                 IW     = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [7:0]         STABLE = 8'(STABLE_CYC);
    localparam logic [NUM_DIG-1:0] ONE    = NUM_DIG'(1);
    localparam logic [NUM_DIG-1:0] FULL   = '1;

    logic [6:0]           seg_s1_q, seg_s2_q;
    logic [NUM_DIG-1:0]   dig_s1_q, dig_s2_q;
    logic [NUM_DIG+6:0]   prev_q;
    logic [7:0]           cnt_q, cnt_d;
    logic                 capt_q, capt_d;

    state_t               state_q, state_d;
    logic [NUM_DIG-1:0]   mask_q, mask_d;
    logic [4*NUM_DIG-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIG-1:0] value_q, value_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [NUM_DIG-1:0]   err_dig_q, err_dig_d;

    logic                 same, fresh, onehot, capture;
    logic [IW-1:0]        dig_idx;
    logic [3:0]           hex;
    logic                 hex_ok;

    sig2hex #(.ROTATE(ROTATE)) u_sig2hex (
        .seg (seg_s2_q),
        .hex (hex),
        .ok  (hex_ok)
    );

    // A dwell is captured exactly once, on the cycle its run length reaches STABLE_CYC.
    always_comb begin
        same    = ({dig_s2_q, seg_s2_q} == prev_q);
        cnt_d   = same ? ((cnt_q == STABLE) ? cnt_q : cnt_q + 8'd1) : 8'd1;
        fresh   = (cnt_d == STABLE) && !(same && capt_q);
        capt_d  = fresh || (same && capt_q);
        onehot  = (dig_s2_q != '0) && ((dig_s2_q & (dig_s2_q - ONE)) == '0);
        capture = fresh && onehot;
        dig_idx = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (dig_s2_q[i]) dig_idx = IW'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            dig_s1_q <= '0;
            dig_s2_q <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            capt_q   <= 1'b0;
        end else begin
            seg_s1_q <= i_seg;
            seg_s2_q <= seg_s1_q;
            dig_s1_q <= i_dig;
            dig_s2_q <= dig_s1_q;
            prev_q   <= {dig_s2_q, seg_s2_q};
            cnt_q    <= cnt_d;
            capt_q   <= capt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        shadow_d  = shadow_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        err_dig_d = err_dig_q;
        case (state_q)
            IDLE: begin
                if (capture && dig_s2_q[0]) begin
                    if (hex_ok) begin
                        shadow_d[3:0] = hex;
                        mask_d        = ONE;
                        state_d       = COLLECT;
                    end else begin
                        err_d     = 1'b1;
                        err_dig_d = ONE;
                    end
                end
            end
            COLLECT: begin
                if (mask_q == FULL) begin
                    value_d = shadow_q;
                    valid_d = 1'b1;
                    mask_d  = '0;
                    state_d = IDLE;
                end else if (capture) begin
                    if (hex_ok && mask_q[dig_idx] && dig_idx == '0) begin
                        // Digit 0 seen again means a new scan began: realign rather than fail.
                        shadow_d[3:0] = hex;
                        mask_d        = ONE;
                    end else if (hex_ok && !mask_q[dig_idx]) begin
                        shadow_d[{dig_idx, 2'b00} +: 4] = hex;
                        mask_d[dig_idx]                 = 1'b1;
                    end else begin
                        err_d     = 1'b1;
                        err_dig_d = dig_s2_q;
                        mask_d    = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                mask_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            shadow_q  <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_dig_q <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            shadow_q  <= shadow_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_dig_q <= err_dig_d;
        end
    end

    assign o_value   = value_q;
    assign o_valid   = valid_q;
    assign o_err     = err_q;
    assign o_err_dig = err_dig_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: standard-order and rotated-order instances share one bus.
module tb_seg_scan_decoder;
    import seg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  seg = SEG_BLANK;
    logic [3:0]  dig = 4'b0000;

    logic [15:0] val0, val1;
    logic        vld0, vld1, err0, err1;
    logic [3:0]  ed0, ed1;

    typedef struct {
        bit          is_err;
        logic [15:0] val;
        logic [3:0]  ed;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   last_vld_cyc = 0;
    int   d3_cyc = 0;
    bit   sel = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_scan_decoder #(.NUM_DIG(4), .STABLE_CYC(8), .ROTATE(0)) u_std (
        .i_clk(clk), .i_rstn(rst_n), .i_seg(seg), .i_dig(dig),
        .o_value(val0), .o_valid(vld0), .o_err(err0), .o_err_dig(ed0)
    );

    seg_scan_decoder #(.NUM_DIG(4), .STABLE_CYC(8), .ROTATE(1)) u_rot (
        .i_clk(clk), .i_rstn(rst_n), .i_seg(seg), .i_dig(dig),
        .o_value(val1), .o_valid(vld1), .o_err(err1), .o_err_dig(ed1)
    );

    wire        vld_s = sel ? vld1 : vld0;
    wire        err_s = sel ? err1 : err0;
    wire [15:0] val_s = sel ? val1 : val0;
    wire [3:0]  ed_s  = sel ? ed1 : ed0;

    // Every output event of the selected instance is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (vld_s || err_s)) begin
            n_vec++;
            if (vld_s) last_vld_cyc = cyc;
            if (vld_s && err_s) begin
                $display("FAIL evt_both: valid=%b err=%b required one of them", vld_s, err_s);
                n_miss++;
            end else if (sb.size() == 0) begin
                $display("FAIL evt_unexpected: valid=%b err=%b value=%h err_dig=%b required no event",
                         vld_s, err_s, val_s, ed_s);
                n_miss++;
            end else begin
                e = sb.pop_front();
                if (e.is_err != err_s) begin
                    $display("FAIL evt_kind: err=%b required err=%b", err_s, e.is_err);
                    n_miss++;
                end else if (!e.is_err && val_s !== e.val) begin
                    $display("FAIL evt_value: got %h required %h", val_s, e.val);
                    n_miss++;
                end else if (e.is_err && ed_s !== e.ed) begin
                    $display("FAIL evt_err_dig: got %b required %b", ed_s, e.ed);
                    n_miss++;
                end
            end
        end
    end

    task automatic push_valid(input logic [15:0] v);
        exp_t x;
        x.is_err = 1'b0; x.val = v; x.ed = 4'b0000;
        sb.push_back(x);
    endtask

    task automatic push_err(input logic [3:0] d);
        exp_t x;
        x.is_err = 1'b1; x.val = 16'h0000; x.ed = d;
        sb.push_back(x);
    endtask

    task automatic show(input logic [6:0] s, input logic [3:0] d, input int n);
        seg = s;
        dig = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                        input logic [6:0] p3, input int dwell, input int blank);
        show(p0, 4'b0001, dwell); show(SEG_BLANK, 4'b0000, blank);
        show(p1, 4'b0010, dwell); show(SEG_BLANK, 4'b0000, blank);
        show(p2, 4'b0100, dwell); show(SEG_BLANK, 4'b0000, blank);
        d3_cyc = cyc;
        show(p3, 4'b1000, dwell); show(SEG_BLANK, 4'b0000, blank);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec += 5;
        if (val0 !== 16'h0000) begin $display("FAIL rst_value: got %h required 0000", val0); n_miss++; end
        if (vld0 !== 1'b0)     begin $display("FAIL rst_valid: got %b required 0", vld0); n_miss++; end
        if (err0 !== 1'b0)     begin $display("FAIL rst_err: got %b required 0", err0); n_miss++; end
        if (ed0 !== 4'b0000)   begin $display("FAIL rst_err_dig: got %b required 0000", ed0); n_miss++; end
        if (val1 !== 16'h0000) begin $display("FAIL rst_value_rot: got %h required 0000", val1); n_miss++; end
        rst_n = 1'b1;
        show(SEG_BLANK, 4'b0000, 4);
    endtask

    task automatic test_basic_frame();
        push_valid(16'h012D);
        scan(7'h21, 7'h24, 7'h79, 7'h40, 20, 5);
        show(SEG_BLANK, 4'b0000, 20);
        n_vec += 3;
        if (sb.size() != 0) begin $display("FAIL basic_pending: got %0d required 0", sb.size()); n_miss++; sb.delete(); end
        if (last_vld_cyc - d3_cyc != 11) begin
            $display("FAIL basic_latency: got %0d required 11", last_vld_cyc - d3_cyc); n_miss++;
        end
        if (val0 !== 16'h012D) begin $display("FAIL basic_value: got %h required 012d", val0); n_miss++; end
    endtask

    task automatic test_short_dwell();
        scan(7'h21, 7'h24, 7'h79, 7'h40, 7, 5);
        show(SEG_BLANK, 4'b0000, 20);
        n_vec++;
        if (val0 !== 16'h012D) begin $display("FAIL short_value: got %h required 012d", val0); n_miss++; end
    endtask

    task automatic test_invalid_pattern();
        push_err(4'b0100);
        scan(7'h21, 7'h24, 7'h7E, 7'h40, 20, 5);
        show(SEG_BLANK, 4'b0000, 20);
        n_vec += 3;
        if (sb.size() != 0) begin $display("FAIL inv_pending: got %0d required 0", sb.size()); n_miss++; sb.delete(); end
        if (val0 !== 16'h012D) begin $display("FAIL inv_value_hold: got %h required 012d", val0); n_miss++; end
        if (ed0 !== 4'b0100) begin $display("FAIL inv_err_dig: got %b required 0100", ed0); n_miss++; end
        push_valid(16'h45F8);
        scan(7'h00, 7'h0E, 7'h12, 7'h19, 20, 5);
        show(SEG_BLANK, 4'b0000, 20);
        n_vec += 3;
        if (sb.size() != 0) begin $display("FAIL inv_recover_pending: got %0d required 0", sb.size()); n_miss++; sb.delete(); end
        if (val0 !== 16'h45F8) begin $display("FAIL inv_recover_value: got %h required 45f8", val0); n_miss++; end
        if (ed0 !== 4'b0100) begin $display("FAIL inv_err_dig_hold: got %b required 0100", ed0); n_miss++; end
    endtask

    task automatic test_repeat_digit();
        push_err(4'b0010);
        show(7'h40, 4'b0001, 20); show(SEG_BLANK, 4'b0000, 5);
        show(7'h79, 4'b0010, 20); show(SEG_BLANK, 4'b0000, 5);
        show(7'h79, 4'b0010, 20); show(SEG_BLANK, 4'b0000, 5);
        show(7'h24, 4'b0100, 20); show(SEG_BLANK, 4'b0000, 5);
        show(7'h30, 4'b1000, 20); show(SEG_BLANK, 4'b0000, 20);
        n_vec += 3;
        if (sb.size() != 0) begin $display("FAIL rep_pending: got %0d required 0", sb.size()); n_miss++; sb.delete(); end
        if (ed0 !== 4'b0010) begin $display("FAIL rep_err_dig: got %b required 0010", ed0); n_miss++; end
        if (val0 !== 16'h45F8) begin $display("FAIL rep_value_hold: got %h required 45f8", val0); n_miss++; end
        push_valid(16'h0123);
        scan(7'h30, 7'h24, 7'h79, 7'h40, 20, 5);
        show(SEG_BLANK, 4'b0000, 20);
        n_vec++;
        if (val0 !== 16'h0123) begin $display("FAIL rep_recover_value: got %h required 0123", val0); n_miss++; end
    endtask

    task automatic test_restart_digit0();
        push_valid(16'hBA98);
        show(7'h02, 4'b0001, 20); show(SEG_BLANK, 4'b0000, 5);
        show(7'h78, 4'b0010, 20); show(SEG_BLANK, 4'b0000, 5);
        scan(7'h00, 7'h18, 7'h08, 7'h03, 20, 5);
        show(SEG_BLANK, 4'b0000, 20);
        n_vec += 2;
        if (sb.size() != 0) begin $display("FAIL restart_pending: got %0d required 0", sb.size()); n_miss++; sb.delete(); end
        if (val0 !== 16'hBA98) begin $display("FAIL restart_value: got %h required ba98", val0); n_miss++; end
    endtask

    task automatic test_back_to_back();
        push_valid(16'h68EC);
        push_valid(16'h9047);
        scan(7'h46, 7'h06, 7'h00, 7'h02, 12, 2);
        scan(7'h78, 7'h19, 7'h40, 7'h18, 12, 2);
        show(SEG_BLANK, 4'b0000, 20);
        n_vec += 2;
        if (sb.size() != 0) begin $display("FAIL b2b_pending: got %0d required 0", sb.size()); n_miss++; sb.delete(); end
        if (val0 !== 16'h9047) begin $display("FAIL b2b_value: got %h required 9047", val0); n_miss++; end
    endtask

    task automatic test_rotate();
        sel = 1'b1;
        push_valid(16'h01FD);
        scan(7'h0C, 7'h31, 7'h4F, 7'h40, 20, 5);
        show(SEG_BLANK, 4'b0000, 20);
        n_vec += 2;
        if (sb.size() != 0) begin $display("FAIL rot_pending: got %0d required 0", sb.size()); n_miss++; sb.delete(); end
        if (val1 !== 16'h01FD) begin $display("FAIL rot_value: got %h required 01fd", val1); n_miss++; end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        show(7'h40, 4'b0001, 20); show(SEG_BLANK, 4'b0000, 5);
        show(7'h79, 4'b0010, 20); show(SEG_BLANK, 4'b0000, 5);
        show(7'h24, 4'b0100, 10);
        rst_n = 1'b0;
        #1;
        n_vec += 3;
        if (val0 !== 16'h0000) begin $display("FAIL mid_rst_value: got %h required 0000", val0); n_miss++; end
        if (vld0 !== 1'b0 || err0 !== 1'b0) begin
            $display("FAIL mid_rst_pulses: valid=%b err=%b required 0 0", vld0, err0); n_miss++;
        end
        if (ed0 !== 4'b0000) begin $display("FAIL mid_rst_err_dig: got %b required 0000", ed0); n_miss++; end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        show(7'h24, 4'b0100, 7); show(SEG_BLANK, 4'b0000, 5);
        show(7'h30, 4'b1000, 20); show(SEG_BLANK, 4'b0000, 20);
        n_vec++;
        if (val0 !== 16'h0000) begin $display("FAIL mid_partial_value: got %h required 0000", val0); n_miss++; end
        push_valid(16'h1234);
        scan(7'h19, 7'h30, 7'h24, 7'h79, 20, 5);
        show(SEG_BLANK, 4'b0000, 20);
        n_vec += 2;
        if (sb.size() != 0) begin $display("FAIL mid_pending: got %0d required 0", sb.size()); n_miss++; sb.delete(); end
        if (val0 !== 16'h1234) begin $display("FAIL mid_new_value: got %h required 1234", val0); n_miss++; end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_short_dwell();
        test_invalid_pattern();
        test_repeat_digit();
        test_restart_digit0();
        test_back_to_back();
        test_rotate();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
